mips_div_unit: RTL and testbench
================================

Name: mips_div_unit

Overview:
Multi-cycle 32-bit integer divider serving the EX stage of the OpenMIPS pipeline for DIV/DIVU.
- EX issues a start request and stalls the pipeline through ctrl until this block returns ready_o.
- Uses radix-2 trial subtraction, one quotient bit per cycle.
- The result is written to HI (remainder) and LO (quotient) through the normal EX/MEM path.

Parameters:
DATA_W, 32, operand width; quotient and remainder are each DATA_W bits.
CNT_W, 6, iteration counter width; must hold the value DATA_W.

Ports:
clk  input  1  system clock; all state changes on the rising edge.
rst  input  1  asynchronous, active-low reset.
signed_div_i  input  1  1 = DIV (signed), 0 = DIVU.
opdata1_i  input  DATA_W  dividend.
opdata2_i  input  DATA_W  divisor.
start_i  input  1  division request from EX; held high until ready_o is seen.
annul_i  input  1  abort the operation in flight (exception or flush).
result_o  output  2*DATA_W  {remainder, quotient}.
ready_o  output  1  result valid.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=FREE, ready_o=0, result_o=0, counter=0, working registers=0.
  - Reset mid-operation discards all progress.
- States:
  - FREE: idle.
  - BYZERO: divisor was zero.
  - ON: iterating.
  - END: result presented.
- FREE, start_i=1 and annul_i=0 sampled at edge E0:
  - If opdata2_i==0, go to BYZERO.
  - Otherwise go to ON and latch both operands, counter=0.
  - When signed_div_i=1, negative operands are replaced by their two's-complement magnitude.
  - Latch the sign of the dividend and the sign of the quotient (dividend XOR divisor sign).
  - start_i=0, or start_i=1 with annul_i=1: remain in FREE.
- BYZERO: at the next edge go to END with quotient=0 and remainder=0. ready_o=1 after edge E1.
- ON, one iteration per edge:
  - Shift the partial remainder left 1 bit and bring in the next dividend MSB.
  - Trial-subtract the divisor magnitude.
  - If the difference is non-negative, keep the difference and shift in quotient bit 1; else keep the shifted value and shift in 0.
  - counter+1 each iteration.
  - When counter reaches DATA_W, go to END at that edge. ready_o=1 and result_o valid after edge E33.
- Sign fixup on entry to END (signed_div_i=1 only):
  - Quotient is negated if the latched quotient sign is 1.
  - Remainder is negated if the dividend was negative, so the remainder takes the sign of the dividend.
  - Overflow case 0x80000000 / -1 yields quotient 0x80000000, remainder 0. No trap is raised.
- annul_i=1 in ON or BYZERO: next edge goes to FREE, ready_o=0, result_o=0. Annul takes priority over completion in the same cycle.
- END: result_o and ready_o are held stable while start_i=1. At the first edge with start_i=0, go to FREE, ready_o=0, result_o=0.
- Operand changes on opdata*_i after E0 have no effect.
- A new start is only accepted from FREE, so there are no back-to-back starts without at least one FREE cycle.
- All outputs are registered; there is no combinational path from any input to any output.

Decomposition:
- Shared package div_pkg holds:
  - State encodings: DivFree, DivByZero, DivOn, DivEnd.
  - DivResultReady / DivResultNotReady, DivStart / DivStop.
  - DATA_W default.
- One natural sub-module: div_trial_sub, the combinational (DATA_W+1)-bit trial subtractor. It returns the difference and a non-negative flag and is instantiated once.

Test Plan:
- Signed DIV of -7 by 2 -> ready_o after E33: quotient 0xFFFFFFFD, remainder 0xFFFFFFFF; ready_o drops one edge after start_i falls.
- Unsigned DIVU of 0xFFFFFFFF by 0x00000010 -> quotient 0x0FFFFFFF, remainder 0x0000000F, latency 33 edges.
- Divisor 0 (either signedness) -> ready_o after E1, result_o=0; no ON cycles seen.
- Signed 0x80000000 by 0xFFFFFFFF -> quotient 0x80000000, remainder 0. Also 100 by -7 gives quotient 0xFFFFFFF2 (-14), remainder 2.
- Pulse annul_i at iteration 10 -> FREE next edge, ready_o stays 0. A following DIVU 20 by 3 then completes with quotient 6, remainder 2.
- Assert rst=0 asynchronously mid-ON (between edges) -> outputs 0 immediately. Release, restart, correct result after a fresh 33 edges.

Source files
------------

// File: rtl/div_pkg.sv
// div_pkg: shared state encodings and handshake constants for the MIPS divider.
package div_pkg;
  localparam int DIV_DATA_W = 32;
  typedef enum logic [1:0] {DivFree, DivByZero, DivOn, DivEnd} div_state_e;
  localparam logic DivResultReady    = 1'b1;
  localparam logic DivResultNotReady = 1'b0;
  localparam logic DivStart          = 1'b1;
  localparam logic DivStop           = 1'b0;
endpackage

// File: rtl/div_trial_sub.sv
// div_trial_sub: (W+1)-bit trial subtraction of the divisor from the shifted partial remainder.
module div_trial_sub #(
  parameter int W = 32
) (
  input  logic [W:0]   minuend,
  input  logic [W-1:0] divisor,
  output logic [W:0]   diff,
  output logic         nonneg
);
  assign diff   = minuend - {1'b0, divisor};
  assign nonneg = ~diff[W];
endmodule

// File: rtl/mips_div_unit.sv
// mips_div_unit: radix-2 restoring divider for DIV/DIVU, one quotient bit per cycle.
// result_o = {remainder, quotient}; outputs depend on registers only.
module mips_div_unit
  import div_pkg::*;
#(
  parameter int DATA_W = DIV_DATA_W,
  parameter int CNT_W  = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  signed_div_i,
  input  logic [DATA_W-1:0]     opdata1_i,
  input  logic [DATA_W-1:0]     opdata2_i,
  input  logic                  start_i,
  input  logic                  annul_i,
  output logic [2*DATA_W-1:0]   result_o,
  output logic                  ready_o
);
  div_state_e state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [DATA_W-1:0] dvd, dvs, rem, op1_mag, op2_mag, quo_fix, rem_fix;
  logic [2*DATA_W-1:0] res;
  logic dvd_neg, quo_neg, nonneg, done, accept;
  logic [DATA_W:0] shifted, diff;
  assign done    = cnt == CNT_W'(DATA_W);
  assign accept  = start_i == DivStart && !annul_i;
  assign op1_mag = (signed_div_i && opdata1_i[DATA_W-1]) ? -opdata1_i : opdata1_i;
  assign op2_mag = (signed_div_i && opdata2_i[DATA_W-1]) ? -opdata2_i : opdata2_i;
  assign quo_fix = quo_neg ? -dvd : dvd;
  assign rem_fix = dvd_neg ? -rem : rem;
  // dvd doubles as the quotient: dividend bits leave at the top while quotient bits enter at the bottom
  assign shifted = {rem, dvd[DATA_W-1]};
  div_trial_sub #(.W(DATA_W)) u_sub (
    .minuend(shifted),
    .divisor(dvs),
    .diff   (diff),
    .nonneg (nonneg)
  );
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= DivFree;
    else state <= state_nxt;
  end
  always_comb begin
    state_nxt = state;
    case (state)
      DivFree:   state_nxt = accept ? (opdata2_i == '0 ? DivByZero : DivOn) : DivFree;
      DivByZero: state_nxt = annul_i ? DivFree : DivEnd;
      DivOn:     state_nxt = annul_i ? DivFree : done ? DivEnd : DivOn;
      DivEnd:    state_nxt = start_i == DivStart ? DivEnd : DivFree;
      default:   state_nxt = DivFree;
    endcase
  end
  always_comb begin
    ready_o  = state == DivEnd ? DivResultReady : DivResultNotReady;
    result_o = state == DivEnd ? res : '0;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt     <= '0;
      dvd     <= '0;
      dvs     <= '0;
      rem     <= '0;
      res     <= '0;
      dvd_neg <= 1'b0;
      quo_neg <= 1'b0;
    end else if (state == DivFree && accept) begin
      cnt     <= '0;
      dvd     <= op1_mag;
      dvs     <= op2_mag;
      rem     <= '0;
      dvd_neg <= signed_div_i & opdata1_i[DATA_W-1];
      quo_neg <= signed_div_i & (opdata1_i[DATA_W-1] ^ opdata2_i[DATA_W-1]);
    end else if (state == DivOn && !annul_i && !done) begin
      rem <= nonneg ? diff[DATA_W-1:0] : shifted[DATA_W-1:0];
      dvd <= {dvd[DATA_W-2:0], nonneg};
      cnt <= cnt + CNT_W'(1);
    end else if (state == DivOn && !annul_i) begin
      res <= {rem_fix, quo_fix};
    end else if (state == DivByZero && !annul_i) begin
      res <= '0;
    end
  end
endmodule

// File: tb/tb_mips_div_unit.sv
// tb_mips_div_unit: directed vectors for DIV/DIVU latency, sign fixup, divide-by-zero, annul and reset.
module tb_mips_div_unit;
  logic clk = 1'b0, rst = 1'b0, signed_div = 1'b0, start = 1'b0, annul = 1'b0;
  logic [31:0] op1 = '0, op2 = '0;
  logic [63:0] result;
  logic ready;
  int checks = 0, errors = 0;
  mips_div_unit dut (
    .clk(clk), .rst(rst), .signed_div_i(signed_div), .opdata1_i(op1), .opdata2_i(op2),
    .start_i(start), .annul_i(annul), .result_o(result), .ready_o(ready)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic run_div(input string tag, input logic sgn, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] q, input logic [31:0] r, input int lat);
    int n;
    logic got;
    logic [63:0] held;
    @(negedge clk);
    signed_div = sgn; op1 = a; op2 = b; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    op1 = ~a; op2 = a ^ b;
    n = 0; got = 1'b0;
    while (!got && n <= 40) begin
      if (ready) got = 1'b1;
      else begin
        @(posedge clk); n++;
        @(negedge clk);
      end
    end
    chk({tag, " latency"}, 64'(n), 64'(lat));
    chk({tag, " quotient"}, 64'(result[31:0]), 64'(q));
    chk({tag, " remainder"}, 64'(result[63:32]), 64'(r));
    held = result;
    @(posedge clk);
    @(negedge clk);
    chk({tag, " hold ready"}, 64'(ready), 64'(1));
    chk({tag, " hold result"}, result, held);
    start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk({tag, " drop ready"}, 64'(ready), 64'(0));
    chk({tag, " drop result"}, result, 64'(0));
  endtask
  initial begin
    #1;
    chk("reset ready", 64'(ready), 64'(0));
    chk("reset result", result, 64'(0));
    @(negedge clk); rst = 1'b1;
    run_div("div -7/2", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 33);
    run_div("divu ffffffff/16", 1'b0, 32'hFFFF_FFFF, 32'h10, 32'h0FFF_FFFF, 32'hF, 33);
    run_div("div by zero", 1'b1, 32'd55, 32'd0, 32'd0, 32'd0, 1);
    run_div("divu by zero", 1'b0, 32'hFFFF_FFFF, 32'd0, 32'd0, 32'd0, 1);
    run_div("div overflow", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 33);
    run_div("divu 80000000/ffffffff", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 33);
    run_div("div 100/-7", 1'b1, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2, 32'd2, 33);
    run_div("div -100/7", 1'b1, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 33);
    // annul part way through the iterations
    @(negedge clk);
    signed_div = 1'b0; op1 = 32'd1000; op2 = 32'd7; start = 1'b1;
    repeat (11) @(posedge clk);
    @(negedge clk);
    annul = 1'b1; start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    annul = 1'b0;
    chk("annul ready", 64'(ready), 64'(0));
    repeat (40) @(posedge clk);
    @(negedge clk);
    chk("annul stays idle", 64'(ready), 64'(0));
    run_div("divu 20/3 after annul", 1'b0, 32'd20, 32'd3, 32'd6, 32'd2, 33);
    // asynchronous reset between edges while iterating
    @(negedge clk);
    signed_div = 1'b1; op1 = 32'd77; op2 = 32'd5; start = 1'b1;
    repeat (6) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("async rst on ready", 64'(ready), 64'(0));
    chk("async rst on result", result, 64'(0));
    start = 1'b0;
    @(negedge clk); rst = 1'b1;
    run_div("div 77/5 after reset", 1'b1, 32'd77, 32'd5, 32'd15, 32'd2, 33);
    // asynchronous reset while a result is being presented
    @(negedge clk);
    signed_div = 1'b0; op1 = 32'd9; op2 = 32'd0; start = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("byzero end ready", 64'(ready), 64'(1));
    #2 rst = 1'b0;
    #1;
    chk("async rst end ready", 64'(ready), 64'(0));
    start = 1'b0;
    @(negedge clk); rst = 1'b1;
    run_div("div -9/-4", 1'b1, 32'hFFFF_FFF7, 32'hFFFF_FFFC, 32'd2, 32'hFFFF_FFFF, 33);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
